// File: rtl/nco_pkg.sv
// Shared types and helpers for the quadrature NCO: quadrant encoding, quarter-wave
// fold rule, and the elaboration-time sine table generator.
package nco_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_e;

    typedef struct packed {
        logic mirror;
        logic negate;
    } fold_t;

    // pi scaled by 2**30
    localparam longint PI_Q30 = 64'sd3373259426;

    function automatic int lut_depth(input int addr_bits);
        return 32'sd1 <<< (addr_bits - 32'sd2);
    endfunction

    // Odd quadrants read the table backwards; the lower half-cycle is negated.
    function automatic fold_t quad_fold(input quadrant_e q);
        fold_t f;
        f = '{mirror: 1'b0, negate: 1'b0};
        case (q)
            Q0:      f = '{mirror: 1'b0, negate: 1'b0};
            Q1:      f = '{mirror: 1'b1, negate: 1'b0};
            Q2:      f = '{mirror: 1'b0, negate: 1'b1};
            Q3:      f = '{mirror: 1'b1, negate: 1'b1};
            default: f = '{mirror: 1'b0, negate: 1'b0};
        endcase
        return f;
    endfunction

    // round((2**(data_bits-1)-1) * sin((idx+0.5)*pi/(2*depth))) via Q30 Taylor series
    function automatic longint sine_entry(input int idx, input int depth, input int data_bits);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint amp;
        x    = ((64'sd2 * longint'(idx)) + 64'sd1) * PI_Q30 / (64'sd4 * longint'(depth));
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 8; k++) begin
            term = -((term * x2) >>> 30) / longint'((32'sd2 * k) * (32'sd2 * k + 32'sd1));
            sum  = sum + term;
        end
        amp = (64'sd1 <<< (data_bits - 32'sd1)) - 64'sd1;
        return (sum * amp + (64'sd1 <<< 29)) >>> 30;
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine magnitude table with two registered read ports, one per
// output channel, so sine and cosine are looked up in the same cycle.
module quarter_sine_rom
    import nco_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_BITS-3:0] addr_a,
    input  logic [ADDR_BITS-3:0] addr_b,
    output logic [DATA_BITS-2:0] data_a,
    output logic [DATA_BITS-2:0] data_b
);

    localparam int DEPTH    = lut_depth(ADDR_BITS);
    localparam int MAG_BITS = DATA_BITS - 1;

    logic [MAG_BITS-1:0] table_s [DEPTH];
    logic [MAG_BITS-1:0] data_a_d;
    logic [MAG_BITS-1:0] data_b_d;
    logic [MAG_BITS-1:0] data_a_q;
    logic [MAG_BITS-1:0] data_b_q;

    // Table contents are fixed at elaboration, so this maps onto ROM/LUT cells.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam longint VALUE = sine_entry(i, DEPTH, DATA_BITS);
        assign table_s[i] = VALUE[MAG_BITS-1:0];
    end

    // Read both ports
    always_comb begin
        data_a_d = table_s[addr_a];
        data_b_d = table_s[addr_b];
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign data_a = data_a_q;
    assign data_b = data_b_q;

endmodule

// File: rtl/quad_nco.sv
// Quadrature NCO: phase accumulator with shadowed, atomically applied frequency/phase
// config, feeding a 3-stage pipeline that emits sine and cosine from one quarter-wave table.
module quad_nco
    import nco_pkg::*;
#(
    parameter int PHASE_BITS = 32,
    parameter int ADDR_BITS  = 10,
    parameter int DATA_BITS  = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [PHASE_BITS-1:0] cfg_freq,
    input  logic [PHASE_BITS-1:0] cfg_phase,
    input  logic                  cfg_sync,
    output logic                  out_valid,
    output logic [DATA_BITS-1:0]  sin_out,
    output logic [DATA_BITS-1:0]  cos_out
);

    localparam int IDX_BITS = ADDR_BITS - 2;
    localparam int MAG_BITS = DATA_BITS - 1;

    logic [PHASE_BITS-1:0] acc_d, acc_q;
    logic [PHASE_BITS-1:0] freq_d, freq_q;
    logic [PHASE_BITS-1:0] phase_d, phase_q;
    logic [PHASE_BITS-1:0] shadow_freq_d, shadow_freq_q;
    logic [PHASE_BITS-1:0] shadow_phase_d, shadow_phase_q;
    logic                  shadow_sync_d, shadow_sync_q;
    logic                  pending_d, pending_q;

    logic [ADDR_BITS-1:0]  p1_d, p1_q;
    logic                  v1_d, v1_q;
    logic                  v2_d, v2_q;
    logic                  sin_neg_d, sin_neg_q;
    logic                  cos_neg_d, cos_neg_q;
    logic [DATA_BITS-1:0]  sin_d, sin_q;
    logic [DATA_BITS-1:0]  cos_d, cos_q;
    logic                  out_valid_d, out_valid_q;

    logic [1:0]            sin_quad_s;
    logic [1:0]            cos_quad_s;
    logic [IDX_BITS-1:0]   idx_s;
    fold_t                 sin_fold_s;
    fold_t                 cos_fold_s;
    logic [IDX_BITS-1:0]   sin_addr_s;
    logic [IDX_BITS-1:0]   cos_addr_s;
    logic [MAG_BITS-1:0]   rom_sin_s;
    logic [MAG_BITS-1:0]   rom_cos_s;
    logic [DATA_BITS-1:0]  sin_mag_s;
    logic [DATA_BITS-1:0]  cos_mag_s;

    // Accumulator and config shadow: a captured config is applied one edge later,
    // and that edge still advances the accumulator with the old frequency.
    always_comb begin
        acc_d          = acc_q;
        freq_d         = freq_q;
        phase_d        = phase_q;
        shadow_freq_d  = shadow_freq_q;
        shadow_phase_d = shadow_phase_q;
        shadow_sync_d  = shadow_sync_q;
        pending_d      = pending_q;

        if (enable) begin
            acc_d = acc_q + freq_q;
        end else begin
            acc_d = acc_q;
        end

        if (pending_q) begin
            freq_d    = shadow_freq_q;
            phase_d   = shadow_phase_q;
            pending_d = 1'b0;
            if (shadow_sync_q) begin
                acc_d = '0;
            end else begin
                acc_d = acc_d;
            end
        end else if (cfg_valid) begin
            shadow_freq_d  = cfg_freq;
            shadow_phase_d = cfg_phase;
            shadow_sync_d  = cfg_sync;
            pending_d      = 1'b1;
        end else begin
            pending_d = 1'b0;
        end
    end

    // Pipeline stages: S1 phase truncation, S2 fold/address, S3 sign application
    always_comb begin
        p1_d = ADDR_BITS'((acc_q + phase_q) >> (PHASE_BITS - ADDR_BITS));
        v1_d = enable;

        sin_quad_s = p1_q[ADDR_BITS-1 -: 2];
        cos_quad_s = sin_quad_s + 2'd1;
        idx_s      = p1_q[IDX_BITS-1:0];
        sin_fold_s = quad_fold(quadrant_e'(sin_quad_s));
        cos_fold_s = quad_fold(quadrant_e'(cos_quad_s));
        if (sin_fold_s.mirror) begin
            sin_addr_s = ~idx_s;
        end else begin
            sin_addr_s = idx_s;
        end
        if (cos_fold_s.mirror) begin
            cos_addr_s = ~idx_s;
        end else begin
            cos_addr_s = idx_s;
        end
        sin_neg_d = sin_fold_s.negate;
        cos_neg_d = cos_fold_s.negate;
        v2_d      = v1_q;

        sin_mag_s = {1'b0, rom_sin_s};
        cos_mag_s = {1'b0, rom_cos_s};
        if (sin_neg_q) begin
            sin_d = {DATA_BITS{1'b0}} - sin_mag_s;
        end else begin
            sin_d = sin_mag_s;
        end
        if (cos_neg_q) begin
            cos_d = {DATA_BITS{1'b0}} - cos_mag_s;
        end else begin
            cos_d = cos_mag_s;
        end
        out_valid_d = v2_q;
    end

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q          <= '0;
            freq_q         <= '0;
            phase_q        <= '0;
            shadow_freq_q  <= '0;
            shadow_phase_q <= '0;
            shadow_sync_q  <= 1'b0;
            pending_q      <= 1'b0;
            p1_q           <= '0;
            v1_q           <= 1'b0;
            v2_q           <= 1'b0;
            sin_neg_q      <= 1'b0;
            cos_neg_q      <= 1'b0;
            sin_q          <= '0;
            cos_q          <= '0;
            out_valid_q    <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            freq_q         <= freq_d;
            phase_q        <= phase_d;
            shadow_freq_q  <= shadow_freq_d;
            shadow_phase_q <= shadow_phase_d;
            shadow_sync_q  <= shadow_sync_d;
            pending_q      <= pending_d;
            p1_q           <= p1_d;
            v1_q           <= v1_d;
            v2_q           <= v2_d;
            sin_neg_q      <= sin_neg_d;
            cos_neg_q      <= cos_neg_d;
            sin_q          <= sin_d;
            cos_q          <= cos_d;
            out_valid_q    <= out_valid_d;
        end
    end

    quarter_sine_rom #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_a (sin_addr_s),
        .addr_b (cos_addr_s),
        .data_a (rom_sin_s),
        .data_b (rom_cos_s)
    );

    assign cfg_ready = ~pending_q;
    assign out_valid = out_valid_q;
    assign sin_out   = sin_q;
    assign cos_out   = cos_q;

endmodule
